// File: rtl/regbank_dump_ctrl.sv
// Debug register-bank dump sequencer: reads registers 0..N_REGISTER-1 over bank
// port A and streams each word MSB byte first to the UART TX valid/ready path.
module regbank_dump_ctrl #(
  parameter int NB_REG     = 5,
  parameter int NB_DATA    = 32,
  parameter int N_REGISTER = 32,
  parameter int NB_BYTE    = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_reg_data,
  input  logic               i_tx_ready,
  output logic [NB_REG-1:0]  o_reg_addr,
  output logic               o_reg_sel,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_busy,
  output logic               o_done
);

  localparam int BYTES  = NB_DATA / NB_BYTE;
  localparam int NB_CNT = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [NB_REG-1:0] LAST_IDX  = NB_REG'(N_REGISTER - 1);
  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPT,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t             r_state;
  logic [NB_REG-1:0]  r_reg_addr;
  logic               r_reg_sel;
  logic               r_tx_valid;
  logic               r_busy;
  logic               r_done;
  logic [NB_CNT-1:0]  r_byte_cnt;
  logic [NB_DATA-1:0] r_shift;
  logic               w_handshake;

  assign w_handshake = r_tx_valid & i_tx_ready;

  // r_reg_addr doubles as the register index; it only moves on the last byte of a word.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_reg_addr <= '0;
      r_reg_sel  <= 1'b0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_reg_addr <= '0;
            r_reg_sel  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_READ;
          end
        end
        ST_READ: begin
          r_state <= ST_CAPT;
        end
        ST_CAPT: begin
          r_shift    <= i_reg_data;
          r_byte_cnt <= '0;
          r_tx_valid <= 1'b1;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          if (w_handshake) begin
            r_shift    <= r_shift << NB_BYTE;
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (r_byte_cnt == LAST_BYTE) begin
              r_tx_valid <= 1'b0;
              if (r_reg_addr == LAST_IDX) begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_reg_addr <= r_reg_addr + 1'b1;
                r_state    <= ST_READ;
              end
            end
          end
        end
        ST_DONE: begin
          r_busy    <= 1'b0;
          r_reg_sel <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_reg_addr = r_reg_addr;
  assign o_reg_sel  = r_reg_sel;
  assign o_tx_data  = r_shift[NB_DATA-1 -: NB_BYTE];
  assign o_tx_valid = r_tx_valid;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_regbank_dump_ctrl.sv
// Bench for regbank_dump_ctrl: registered bank model plus a byte scoreboard
// filled at dump start and drained on every TX handshake.
module tb_regbank_dump_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        ready;
  logic [31:0] reg_data;
  logic [4:0]  reg_addr;
  logic        reg_sel;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;

  logic [31:0] bank [32];
  logic [7:0]  exp_q [$];
  logic [7:0]  exp_b;
  logic [7:0]  stall_data;
  bit          stall_prev;
  bit          busy_prev;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_count = 0;
  int done_count = 0;
  int done_cyc = 0;
  int first_done_cyc = 0;
  int busy_rise_cyc = 0;

  regbank_dump_ctrl #(
    .NB_REG(5), .NB_DATA(32), .N_REGISTER(32), .NB_BYTE(8)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_start(start),
    .i_reg_data(reg_data),
    .i_tx_ready(ready),
    .o_reg_addr(reg_addr),
    .o_reg_sel(reg_sel),
    .o_tx_data(tx_data),
    .o_tx_valid(tx_valid),
    .o_busy(busy),
    .o_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    reg_data <= bank[reg_addr];
  end

  // Scoreboard drain, hold-under-backpressure check and event timestamps.
  always @(negedge clk) begin
    if (tx_valid === 1'b1 && ready === 1'b1) begin
      hs_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_byte: got %02h, scoreboard empty", tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (tx_data !== exp_b) begin
          errors++;
          $display("[TB] FAIL byte_%0d: got %02h, expected %02h", hs_count - 1, tx_data, exp_b);
        end
      end
    end
    if (stall_prev) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== stall_data) begin
        errors++;
        $display("[TB] FAIL hold_stable: got valid=%0b data=%02h, expected valid=1 data=%02h",
                 tx_valid, tx_data, stall_data);
      end
    end
    stall_prev = (tx_valid === 1'b1) && (ready === 1'b0) && (rst === 1'b0);
    stall_data = tx_data;
    if (done === 1'b1) begin
      if (done_count == 0) first_done_cyc = cyc;
      done_cyc = cyc;
      done_count++;
    end
    if (busy === 1'b1 && !busy_prev) busy_rise_cyc = cyc;
    busy_prev = (busy === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump();
    for (int n = 0; n < 32; n++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(bank[n][31-8*b -: 8]);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    hs_count = 0;
    done_count = 0;
  endtask

  task automatic run_until_done(input int target, input int budget, input bit bp, input int pulse_at);
    bit [3:0] pat;
    bit pulsed;
    pat = 4'b1001;
    pulsed = 1'b0;
    for (int i = 0; i < budget && done_count < target; i++) begin
      ready = bp ? pat[i % 4] : 1'b1;
      if (pulse_at >= 0) begin
        if (!pulsed && hs_count == pulse_at) begin
          start = 1'b1;
          pulsed = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
      tick();
    end
    ready = 1'b1;
    checks++;
    if (done_count < target) begin
      errors++;
      $display("[TB] FAIL done_timeout: got %0d done pulses, expected %0d", done_count, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    tick();
    tick();
    checks++;
    if ({reg_addr, reg_sel, tx_data, tx_valid, busy, done} !== 17'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %05h, expected 00000",
               {reg_addr, reg_sel, tx_data, tx_valid, busy, done});
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || reg_sel !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got busy=%0b sel=%0b, expected 0 0", busy, reg_sel);
    end
  endtask

  task automatic test_full_dump();
    int e;
    clear_sb();
    push_dump();
    start = 1'b1;
    tick();
    start = 1'b0;
    e = cyc;
    checks++;
    if ({busy, reg_sel, tx_valid} !== 3'b110 || reg_addr !== 5'd0) begin
      errors++;
      $display("[TB] FAIL read_cycle: got busy/sel/valid=%03b addr=%0d, expected 110 addr=0",
               {busy, reg_sel, tx_valid}, reg_addr);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b0 || reg_addr !== 5'd0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL capt_cycle: got valid=%0b addr=%0d busy=%0b, expected 0 0 1",
               tx_valid, reg_addr, busy);
    end
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
      errors++;
      $display("[TB] FAIL first_valid: got valid=%0b data=%02h, expected 1 01", tx_valid, tx_data);
    end
    run_until_done(1, 400, 1'b0, -1);
    checks++;
    if (done_cyc != e + 192) begin
      errors++;
      $display("[TB] FAIL done_latency: got %0d cycles after start edge, expected 193", done_cyc - e + 1);
    end
    checks++;
    if (hs_count != 128 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL full_count: got %0d bytes (%0d left), expected 128 (0 left)", hs_count, exp_q.size());
    end
    checks++;
    if (busy !== 1'b0 || reg_sel !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_done: got busy=%0b sel=%0b valid=%0b, expected 0 0 0",
               busy, reg_sel, tx_valid);
    end
  endtask

  task automatic test_backpressure();
    clear_sb();
    push_dump();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_until_done(1, 2000, 1'b1, -1);
    checks++;
    if (hs_count != 128 || exp_q.size() != 0 || done_count != 1) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d bytes, %0d done, expected 128 bytes, 1 done", hs_count, done_count);
    end
  endtask

  task automatic test_start_ignored();
    clear_sb();
    push_dump();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_until_done(1, 400, 1'b0, 21);
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (done_count != 1 || hs_count != 128 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL start_ignored: got %0d done, %0d bytes, expected 1 done, 128 bytes", done_count, hs_count);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_restart: got busy=%0b, expected 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    int e;
    clear_sb();
    push_dump();
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (hs_count != 42 && guard < 400) begin
      tick();
      guard++;
    end
    checks++;
    if (hs_count != 42 || tx_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reach_reg10_byte2: got %0d bytes valid=%0b, expected 42 valid=1", hs_count, tx_valid);
    end
    rst = 1'b1;
    ready = 1'b0;
    tick();
    checks++;
    if ({reg_addr, reg_sel, tx_data, tx_valid, busy, done} !== 17'h0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got %05h, expected 00000", {reg_addr, reg_sel, tx_data, tx_valid, busy, done});
    end
    rst = 1'b0;
    ready = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got busy=%0b valid=%0b, expected 0 0", busy, tx_valid);
    end
    clear_sb();
    push_dump();
    start = 1'b1;
    tick();
    start = 1'b0;
    e = cyc;
    tick();
    tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
      errors++;
      $display("[TB] FAIL restart_first_byte: got valid=%0b data=%02h, expected 1 01", tx_valid, tx_data);
    end
    run_until_done(1, 400, 1'b0, -1);
    checks++;
    if (done_cyc != e + 192 || hs_count != 128 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL restart_dump: got done at +%0d with %0d bytes, expected +193 with 128",
               done_cyc - e + 1, hs_count);
    end
  endtask

  task automatic test_addr_timing();
    int guard;
    int idx;
    bit gap;
    bit gap_prev;
    bank[31] = 32'hDEADBEEF;
    clear_sb();
    push_dump();
    start = 1'b1;
    tick();
    start = 1'b0;
    gap_prev = 1'b0;
    guard = 0;
    while (done_count < 1 && guard < 400) begin
      gap = (busy === 1'b1) && (tx_valid === 1'b0) && (done === 1'b0);
      if (gap) begin
        idx = hs_count / 4;
        checks++;
        if (reg_addr !== 5'(idx) || reg_sel !== 1'b1) begin
          errors++;
          $display("[TB] FAIL addr_reg%0d: got addr=%0d sel=%0b, expected addr=%0d sel=1", idx, reg_addr, reg_sel, idx);
        end
        if (gap_prev) begin
          checks++;
          if (reg_data !== bank[idx]) begin
            errors++;
            $display("[TB] FAIL capt_data_reg%0d: got %08h, expected %08h", idx, reg_data, bank[idx]);
          end
        end
      end
      gap_prev = gap;
      tick();
      guard++;
    end
    checks++;
    if (done_count != 1 || hs_count != 128 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL addr_dump: got %0d done, %0d bytes, expected 1 done, 128 bytes", done_count, hs_count);
    end
    bank[31] = 32'h0102031F;
  endtask

  task automatic test_back_to_back();
    clear_sb();
    push_dump();
    push_dump();
    start = 1'b1;
    run_until_done(2, 800, 1'b0, -1);
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (done_count != 2 || hs_count != 256 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d done, %0d bytes, expected 2 done, 256 bytes", done_count, hs_count);
    end
    checks++;
    if (busy_rise_cyc != first_done_cyc + 2) begin
      errors++;
      $display("[TB] FAIL b2b_idle_gap: got next READ %0d cycles after done, expected 2", busy_rise_cyc - first_done_cyc);
    end
    checks++;
    if (done_cyc != first_done_cyc + 194) begin
      errors++;
      $display("[TB] FAIL b2b_period: got %0d cycles between dones, expected 194", done_cyc - first_done_cyc);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_stop: got busy=%0b, expected 0", busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    stall_prev = 1'b0;
    busy_prev = 1'b0;
    for (int n = 0; n < 32; n++) bank[n] = 32'h01020300 + 32'(n);
    test_reset();
    test_full_dump();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_addr_timing();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
